// File: rtl/temp_pkg.sv
// ---------------------------------------------------------------------------
// temp_pkg
// Shared definitions for the temperature-sensor controller and its readers.
//
// Contents:
//   ST_WARMUP/ST_PTAT/ST_CTAT/ST_ILLEGAL - 2-bit controller state encodings
//   rd_state_e                           - reader pairing FSM states
//   TEMP_CW                              - default controller count width
//   is_phase_state()                     - true for the two comparator phases
// ---------------------------------------------------------------------------
package temp_pkg;

    // Controller state encodings. PTAT and CTAT differ in one bit so the
    // controller can toggle between them cheaply; 2'd2 is never produced by
    // a healthy controller.
    localparam logic [1:0] ST_WARMUP  = 2'd0;
    localparam logic [1:0] ST_PTAT    = 2'd1;
    localparam logic [1:0] ST_CTAT    = 2'd3;
    localparam logic [1:0] ST_ILLEGAL = 2'd2;

    // Default width of the controller phase counter.
    localparam int TEMP_CW = 8;

    // Reader pairing FSM: waiting for a PTAT phase to end, or holding a PTAT
    // length and waiting for the matching CTAT phase to end.
    typedef enum logic {
        WAIT_PTAT = 1'b0,
        WAIT_CTAT = 1'b1
    } rd_state_e;

    // A state in which the controller is timing a comparator phase.
    function automatic logic is_phase_state(input logic [1:0] st);
        return (st == ST_PTAT) || (st == ST_CTAT);
    endfunction

endpackage

// File: rtl/temp_phase_detect.sv
// ---------------------------------------------------------------------------
// temp_phase_detect
// Registers the controller state/count once per cycle and decodes phase
// events from the (previous, current) pair. Every event is therefore
// reported one cycle after the controller changes state.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   i_state      - controller state
//   i_count      - controller phase counter
//   i_idle       - reader has nothing in flight (no held PTAT, no pairs)
//   o_ptat_end   - a PTAT phase just finished (PTAT -> CTAT)
//   o_ctat_end   - a CTAT phase just finished (CTAT -> PTAT)
//   o_wrap       - the phase counter wrapped from all-ones to zero
//   o_abort      - in-flight accumulation must be discarded
//   o_illegal    - controller is in the unused state encoding
//   o_len        - length of the phase that just finished
// ---------------------------------------------------------------------------
module temp_phase_detect
    import temp_pkg::*;
#(
    parameter int CW = TEMP_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    i_state,
    input  logic [CW-1:0] i_count,
    input  logic          i_idle,
    output logic          o_ptat_end,
    output logic          o_ctat_end,
    output logic          o_wrap,
    output logic          o_abort,
    output logic          o_illegal,
    output logic [CW-1:0] o_len
);

    logic [1:0]    r_prev_state;
    logic [CW-1:0] r_prev_count;

    logic w_warmup;
    logic w_same_phase;

    // History registers. Reset to WARMUP so that the first real phase after
    // reset is never mistaken for the end of a previous one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_state <= ST_WARMUP;
            r_prev_count <= '0;
        end else begin
            r_prev_state <= i_state;
            r_prev_count <= i_count;
        end
    end

    // The controller holds count at the terminal value for the cycle before
    // it switches, so the previous count is the completed phase length.
    assign o_len = r_prev_count;

    assign o_ptat_end = (r_prev_state == ST_PTAT) && (i_state == ST_CTAT);
    assign o_ctat_end = (r_prev_state == ST_CTAT) && (i_state == ST_PTAT);

    // A wrap is only meaningful while the same phase keeps running; a
    // counter restart at a phase boundary is not a wrap.
    assign w_same_phase = (r_prev_state == i_state) && is_phase_state(i_state);
    assign o_wrap       = w_same_phase
                        && (r_prev_count == {CW{1'b1}})
                        && (i_count == '0);

    assign o_illegal = (i_state == ST_ILLEGAL);
    assign w_warmup  = (i_state == ST_WARMUP);

    // WARMUP only destroys work in progress; when the reader is idle it is
    // harmless. The illegal state always forces a clean restart.
    assign o_abort = o_illegal || (w_warmup && !i_idle);

endmodule

// File: rtl/temp_sample_reader.sv
// ---------------------------------------------------------------------------
// temp_sample_reader
// Watches the temperature-sensor controller, pairs each PTAT phase length
// with the following CTAT phase length, sums 2**AVG_LOG2 such pairs and
// hands the sums downstream over a valid/ready handshake.
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   i_state        - controller state (see temp_pkg encodings)
//   i_count        - controller phase counter
//   i_clear        - clears the sticky error flags
//   o_res_valid    - result register holds a result
//   i_res_ready    - downstream accepts the result
//   o_res_ptat     - sum of PTAT phase lengths
//   o_res_ctat     - sum of CTAT phase lengths
//   o_res_ovf      - a phase in this result wrapped the counter
//   o_err_lost     - sticky: a completed result could not be stored
//   o_err_illegal  - sticky: illegal controller state observed
//   o_busy         - accumulation in progress
// ---------------------------------------------------------------------------
module temp_sample_reader
    import temp_pkg::*;
#(
    parameter int CW       = TEMP_CW,
    parameter int AVG_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             i_state,
    input  logic [CW-1:0]          i_count,
    input  logic                   i_clear,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [CW+AVG_LOG2-1:0] o_res_ptat,
    output logic [CW+AVG_LOG2-1:0] o_res_ctat,
    output logic                   o_res_ovf,
    output logic                   o_err_lost,
    output logic                   o_err_illegal,
    output logic                   o_busy
);

    // Sum width is fixed by the counter width and the averaging depth; the
    // largest possible sum (2**CW-1)*2**AVG_LOG2 always fits.
    localparam int SW  = CW + AVG_LOG2;
    // Pair counter must be able to hold 2**AVG_LOG2 itself.
    localparam int PCW = AVG_LOG2 + 1;
    localparam logic [PCW-1:0] PAIRS = PCW'(2 ** AVG_LOG2);

    // Accumulation state
    rd_state_e      r_fsm;
    logic [CW-1:0]  r_ptat_hold;
    logic [SW-1:0]  r_acc_p;
    logic [SW-1:0]  r_acc_c;
    logic [PCW-1:0] r_pair_cnt;
    logic           r_phase_ovf;

    // Output register and sticky flags
    logic           r_res_valid;
    logic [SW-1:0]  r_res_ptat;
    logic [SW-1:0]  r_res_ctat;
    logic           r_res_ovf;
    logic           r_err_lost;
    logic           r_err_illegal;

    // Decoded events
    logic           w_ptat_end;
    logic           w_ctat_end;
    logic           w_wrap;
    logic           w_abort;
    logic           w_illegal;
    logic [CW-1:0]  w_len;

    logic           w_idle;
    logic           w_pair_done;
    logic [PCW-1:0] w_pair_next;
    logic [SW-1:0]  w_sum_p;
    logic [SW-1:0]  w_sum_c;
    logic           w_complete;
    logic           w_out_free;
    logic           w_xfer;

    assign w_idle = (r_fsm == WAIT_PTAT) && (r_pair_cnt == '0);

    temp_phase_detect #(
        .CW (CW)
    ) u_detect (
        .clk        (clk),
        .reset      (reset),
        .i_state    (i_state),
        .i_count    (i_count),
        .i_idle     (w_idle),
        .o_ptat_end (w_ptat_end),
        .o_ctat_end (w_ctat_end),
        .o_wrap     (w_wrap),
        .o_abort    (w_abort),
        .o_illegal  (w_illegal),
        .o_len      (w_len)
    );

    // A CTAT end only closes a pair if a PTAT length is being held; a stray
    // CTAT end (pairing out of step) is dropped.
    assign w_pair_done = w_ctat_end && (r_fsm == WAIT_CTAT);
    assign w_pair_next = r_pair_cnt + PCW'(1);
    assign w_sum_p     = r_acc_p + SW'(r_ptat_hold);
    assign w_sum_c     = r_acc_c + SW'(w_len);
    assign w_complete  = w_pair_done && (w_pair_next == PAIRS);

    // The output register can accept a new result when it is empty or is
    // being emptied this very cycle.
    assign w_xfer     = r_res_valid && i_res_ready;
    assign w_out_free = !r_res_valid || i_res_ready;

    // Pairing FSM, accumulators, output register and sticky flags. Abort has
    // priority over every accumulation event but never touches a result that
    // is already waiting in the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm         <= WAIT_PTAT;
            r_ptat_hold   <= '0;
            r_acc_p       <= '0;
            r_acc_c       <= '0;
            r_pair_cnt    <= '0;
            r_phase_ovf   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_ptat    <= '0;
            r_res_ctat    <= '0;
            r_res_ovf     <= 1'b0;
            r_err_lost    <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            // Result register: a completion overwrites an accepted result
            // directly, giving back-to-back valid cycles.
            if (w_complete && w_out_free) begin
                r_res_valid <= 1'b1;
                r_res_ptat  <= w_sum_p;
                r_res_ctat  <= w_sum_c;
                r_res_ovf   <= r_phase_ovf || w_wrap;
            end else if (w_xfer) begin
                r_res_valid <= 1'b0;
            end

            // Sticky flags: a setting event beats a simultaneous clear.
            if (w_complete && !w_out_free) begin
                r_err_lost <= 1'b1;
            end else if (i_clear) begin
                r_err_lost <= 1'b0;
            end

            if (w_illegal) begin
                r_err_illegal <= 1'b1;
            end else if (i_clear) begin
                r_err_illegal <= 1'b0;
            end

            if (w_abort) begin
                r_fsm       <= WAIT_PTAT;
                r_ptat_hold <= '0;
                r_acc_p     <= '0;
                r_acc_c     <= '0;
                r_pair_cnt  <= '0;
                r_phase_ovf <= 1'b0;
            end else begin
                // The wrapped length is kept as-is; only the flag records it.
                if (w_wrap) begin
                    r_phase_ovf <= 1'b1;
                end

                if (w_ptat_end) begin
                    r_ptat_hold <= w_len;
                    r_fsm       <= WAIT_CTAT;
                end else if (w_pair_done) begin
                    r_fsm <= WAIT_PTAT;
                    // Completed results start the next window from zero,
                    // whether or not the result could be stored.
                    if (w_complete) begin
                        r_acc_p     <= '0;
                        r_acc_c     <= '0;
                        r_pair_cnt  <= '0;
                        r_phase_ovf <= 1'b0;
                    end else begin
                        r_acc_p    <= w_sum_p;
                        r_acc_c    <= w_sum_c;
                        r_pair_cnt <= w_pair_next;
                    end
                end
            end
        end
    end

    assign o_res_valid   = r_res_valid;
    assign o_res_ptat    = r_res_ptat;
    assign o_res_ctat    = r_res_ctat;
    assign o_res_ovf     = r_res_ovf;
    assign o_err_lost    = r_err_lost;
    assign o_err_illegal = r_err_illegal;
    assign o_busy        = (r_fsm == WAIT_CTAT) || (r_pair_cnt != '0);

endmodule

// File: doc/temp_sample_reader.md
Name: temp_sample_reader

Overview:
- Observer and consumer of the temperature-sensor controller's `state`/`count` outputs, running on the same `clk`.
- Extracts the terminal cycle count of every PTAT and CTAT comparator phase and pairs them (PTAT then CTAT).
- Accumulates 2**AVG_LOG2 pairs and presents the sums to downstream logic over a valid/ready handshake, with overflow and lost-result flags.

Parameters:
- CW, 8, controller count width.
- AVG_LOG2, 2, log2 of number of PTAT/CTAT pairs accumulated per result (0..6).
- SW, CW+AVG_LOG2, sum width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- state  in  2  controller state (0 WARMUP, 1 PTAT, 3 CTAT, 2 illegal)
- count  in  CW  controller phase counter
- clear  in  1  synchronous clear of sticky flags (err_lost, err_illegal)
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_ptat  out  SW  sum of PTAT phase lengths
- res_ctat  out  SW  sum of CTAT phase lengths
- res_ovf  out  1  at least one phase in this result wrapped the CW counter
- err_lost  out  1  sticky: a completed result was dropped
- err_illegal  out  1  sticky: state==2 observed
- busy  out  1  accumulation in progress (>=1 phase captured)

Behaviour:
- Reset values: every output is 0 and every internal register is 0. The internal registers are prev_state=WARMUP, prev_count, ptat_hold, acc_p, acc_c, pair_cnt, phase_ovf and the FSM.
- Sampling: prev_state/prev_count register state/count every cycle. All events are decoded from the (prev, current) pair, so detection is one cycle after the controller changes state.
- PTAT end: prev_state==PTAT && state==CTAT.
  - Phase length L = prev_count.
  - Latch ptat_hold=L; FSM WAIT_PTAT -> WAIT_CTAT.
- CTAT end: prev_state==CTAT && state==PTAT, in FSM WAIT_CTAT.
  - Add prev_count to acc_c and ptat_hold to acc_p, both zero-extended to SW.
  - pair_cnt+=1. FSM -> WAIT_PTAT.
- CTAT end seen in WAIT_PTAT (pairing out of step): ignore it; no accumulation.
- Wrap: prev_state==state in {PTAT,CTAT}, prev_count=={CW{1}} and count==0.
  - Set phase_ovf. The phase length captured is the wrapped value, no correction.
  - phase_ovf ORs into result ovf and clears when a result is emitted.
- Abort: state==WARMUP while FSM != WAIT_PTAT, or any pair_cnt>0.
  - Discard acc_p, acc_c, pair_cnt, ptat_hold and phase_ovf; FSM -> WAIT_PTAT.
  - A result already held in the output register is unaffected.
- Illegal state==2: set err_illegal and apply the abort action.
- Completion: when pair_cnt reaches 2**AVG_LOG2 on a CTAT end, the final sums (including the current pair) form the result.
  - Output register free (res_valid==0, or res_ready==1 in the same cycle): load res_ptat/res_ctat/res_ovf. res_valid=1 next cycle.
  - Output register busy (res_valid && !res_ready): drop the new result and set err_lost.
  - In either case, clear the accumulators, pair_cnt and phase_ovf.
- Handshake:
  - res_valid stays high, with stable data, until res_valid&&res_ready.
  - Transfer plus a new completion in the same cycle gives back-to-back valid with the new data.
  - Transfer without a new completion lowers res_valid next cycle.
- No arithmetic overflow is possible: max sum = (2**CW-1)*2**AVG_LOG2 < 2**SW.
- clear zeroes err_lost and err_illegal. If clear coincides with a setting event, the set wins.
- busy = (FSM==WAIT_CTAT) || pair_cnt!=0.
- reset mid-accumulation or mid-handshake returns to reset values at the next edge.

Decomposition:
- Shared package temp_pkg holds:
  - state encodings ST_WARMUP=2'd0, ST_PTAT=2'd1, ST_CTAT=2'd3, ST_ILLEGAL=2'd2 (shared with the controller);
  - the reader FSM enum (WAIT_PTAT, WAIT_CTAT);
  - CW default 8.
- One natural sub-module: temp_phase_detect. It holds the prev registers and decodes ptat_end, ctat_end, wrap, abort, illegal and len.
- Accumulation, FSM and the output register stay in temp_sample_reader.

Test Plan:
- AVG_LOG2=0; drive WARMUP, then PTAT counting 0..40, then CTAT 0..25, then PTAT -> res_valid one cycle after the CTAT->PTAT edge, res_ptat=40, res_ctat=25, res_ovf=0.
- AVG_LOG2=2; pairs (10,20),(11,21),(12,22),(13,23) with res_ready=1 -> single result 46/86; busy is 0 after the emit.
- PTAT counts past 255 to 4 then CTAT=7 (AVG_LOG2=0) -> res_ptat=4, res_ctat=7, res_ovf=1; the next result has res_ovf=0.
- res_ready=0 while two AVG_LOG2=0 results complete -> first result held stable, err_lost=1. clear=1 -> err_lost=0.
- WARMUP inserted after the PTAT end but before the CTAT end -> no result, busy=0; the next clean pair gives the correct values.
- state=2 for one cycle mid-accumulation -> err_illegal=1 and accumulation discarded; reset mid-handshake -> res_valid=0 next cycle.
